sseg_iomem: RTL and testbench

- Memory-mapped 3-digit seven-segment display controller on the picosoc iomem bus.
- Sits directly downstream of picosoc: consumes CPU register writes, drives the board SevenSegment/SevenSegmentEN pins.
- Time-multiplexes three digits with a refresh counter.
- Supports hex-decode mode and raw-segment mode.

---
 rtl/sseg_iomem_if.sv | 25 ++
 rtl/sseg_iomem.sv | 212 +++++++++++++++++++++
 tb/tb_sseg_iomem.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sseg_iomem_if.sv
`default_nettype none
// ============================================================================
// Module   : sseg_iomem_if
// Purpose  : picosoc iomem bus bundle for the seven-segment controller.
// Revision : 1.0 - initial release
// ============================================================================
interface sseg_iomem_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/sseg_iomem.sv
`default_nettype none
// ============================================================================
// Module   : sseg_iomem
// Purpose  : Memory-mapped 3-digit multiplexed seven-segment controller on
//            the picosoc iomem bus. Optional macro SSEG_DIM_EN adds a 4-bit
//            brightness register at offset 0xC.
// Revision : 1.0 - initial release
// ============================================================================
module sseg_iomem #(
    parameter logic [31:0] ADDR_BASE       = 32'h0300_0000,
    parameter int          TICKS_PER_DIGIT = 33333,
    parameter int          CNT_W           = 16
) (
    input  logic        clk,
    input  logic        resetn,
    sseg_iomem_if.slave bus,
    output logic [7:0]  ss,
    output logic [2:0]  ssen
);

    localparam logic [3:0]       c_OFS_DATA   = 4'h0;
    localparam logic [3:0]       c_OFS_CTRL   = 4'h4;
    localparam logic [3:0]       c_OFS_RAW    = 4'h8;
    localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(TICKS_PER_DIGIT - 1);

    localparam logic [1:0] c_DIG0 = 2'd0;
    localparam logic [1:0] c_DIG1 = 2'd1;
    localparam logic [1:0] c_DIG2 = 2'd2;

    logic             r_ready;
    logic [31:0]      r_rdata;
    logic [14:0]      r_data;
    logic [1:0]       r_ctrl;
    logic [23:0]      r_raw;
    logic [14:0]      r_sh_data;
    logic [1:0]       r_sh_ctrl;
    logic [23:0]      r_sh_raw;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [7:0]       r_ss;
    logic [2:0]       r_ssen;

    logic             w_sel;
    logic             w_accept;
    logic [3:0]       w_ofs;
    logic [3:0]       w_we;
    logic [31:0]      w_rdata;
    logic [3:0]       w_nib;
    logic             w_dp;
    logic [7:0]       w_raw_byte;
    logic [6:0]       w_seg;
    logic             w_lit;
    logic             w_unused;

    assign w_sel    = bus.iomem_valid && (bus.iomem_addr[31:4] == ADDR_BASE[31:4]);
    assign w_accept = w_sel && !r_ready;
    assign w_ofs    = bus.iomem_addr[3:0];
    assign w_we     = w_accept ? bus.iomem_wstrb : 4'h0;
    assign w_unused = &{1'b0, bus.iomem_wdata[31:24], bus.iomem_wdata[15]};

`ifdef SSEG_DIM_EN
    localparam logic [3:0] c_OFS_BRIGHT = 4'hC;
    logic [3:0] r_bright;
    logic [3:0] r_sh_bright;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bright    <= 4'hF;
            r_sh_bright <= 4'hF;
        end else begin
            if (w_ofs == c_OFS_BRIGHT && w_we[0]) begin
                r_bright <= bus.iomem_wdata[3:0];
            end
            r_sh_bright <= r_bright;
        end
    end

    // Digit lit only during the first L+1 ticks of every 16-tick window.
    assign w_lit = (r_cnt != '0) && (4'(r_cnt) <= r_sh_bright);
`else
    assign w_lit = (r_cnt != '0);
`endif

    always_comb begin
        w_rdata = 32'h0;
        case (w_ofs)
            c_OFS_DATA:   w_rdata = {17'h0, r_data};
            c_OFS_CTRL:   w_rdata = {30'h0, r_ctrl};
            c_OFS_RAW:    w_rdata = {8'h0, r_raw};
`ifdef SSEG_DIM_EN
            c_OFS_BRIGHT: w_rdata = {28'h0, r_bright};
`endif
            default:      w_rdata = 32'h0;
        endcase
    end

    // Bus side: one-cycle ack, writes commit on the edge that raises ready.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready <= 1'b0;
            r_rdata <= 32'h0;
            r_data  <= 15'h0;
            r_ctrl  <= 2'b01;
            r_raw   <= 24'h0;
        end else begin
            r_ready <= w_accept;
            r_rdata <= w_accept ? w_rdata : 32'h0;
            if (w_ofs == c_OFS_DATA) begin
                if (w_we[0]) r_data[7:0]  <= bus.iomem_wdata[7:0];
                if (w_we[1]) r_data[14:8] <= bus.iomem_wdata[14:8];
            end
            if (w_ofs == c_OFS_CTRL && w_we[0]) begin
                r_ctrl <= bus.iomem_wdata[1:0];
            end
            if (w_ofs == c_OFS_RAW) begin
                if (w_we[0]) r_raw[7:0]   <= bus.iomem_wdata[7:0];
                if (w_we[1]) r_raw[15:8]  <= bus.iomem_wdata[15:8];
                if (w_we[2]) r_raw[23:16] <= bus.iomem_wdata[23:16];
            end
        end
    end

    // Display snapshot decouples bus commits from the output stage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sh_data <= 15'h0;
            r_sh_ctrl <= 2'b01;
            r_sh_raw  <= 24'h0;
        end else begin
            r_sh_data <= r_data;
            r_sh_ctrl <= r_ctrl;
            r_sh_raw  <= r_raw;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
            r_idx <= c_DIG0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_cnt <= '0;
            case (r_idx)
                c_DIG0:  r_idx <= c_DIG1;
                c_DIG1:  r_idx <= c_DIG2;
                default: r_idx <= c_DIG0;
            endcase
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_nib      = r_sh_data[3:0];
        w_dp       = r_sh_data[12];
        w_raw_byte = r_sh_raw[7:0];
        case (r_idx)
            c_DIG1: begin
                w_nib      = r_sh_data[7:4];
                w_dp       = r_sh_data[13];
                w_raw_byte = r_sh_raw[15:8];
            end
            c_DIG2: begin
                w_nib      = r_sh_data[11:8];
                w_dp       = r_sh_data[14];
                w_raw_byte = r_sh_raw[23:16];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_seg = 7'h00;
        case (w_nib)
            4'h0: w_seg = 7'h3F;
            4'h1: w_seg = 7'h06;
            4'h2: w_seg = 7'h5B;
            4'h3: w_seg = 7'h4F;
            4'h4: w_seg = 7'h66;
            4'h5: w_seg = 7'h6D;
            4'h6: w_seg = 7'h7D;
            4'h7: w_seg = 7'h07;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h6F;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h7C;
            4'hC: w_seg = 7'h39;
            4'hD: w_seg = 7'h5E;
            4'hE: w_seg = 7'h79;
            default: w_seg = 7'h71;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ss   <= 8'hFF;
            r_ssen <= 3'b111;
        end else if (!r_sh_ctrl[0]) begin
            r_ss   <= 8'hFF;
            r_ssen <= 3'b111;
        end else begin
            r_ss   <= r_sh_ctrl[1] ? ~w_raw_byte : ~{w_dp, w_seg};
            r_ssen <= w_lit ? ~(3'b001 << r_idx) : 3'b111;
        end
    end

    assign bus.iomem_ready = r_ready;
    assign bus.iomem_rdata = r_rdata;
    assign ss              = r_ss;
    assign ssen            = r_ssen;

endmodule
`default_nettype wire

// File: tb/tb_sseg_iomem.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_iomem
// Purpose  : Self-checking bench for sseg_iomem (vector table, hand-written
//            corner sequences, randomized bus traffic vs. a reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_iomem;
    localparam int          T    = 4;
    localparam logic [31:0] BASE = 32'h0300_0000;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] ss;
    logic [2:0] ssen;

    sseg_iomem_if bus_i ();

    sseg_iomem #(.ADDR_BASE(BASE), .TICKS_PER_DIGIT(T), .CNT_W(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_i),
        .ss     (ss),
        .ssen   (ssen)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Register contents as the CPU has committed them, and as the display sees them.
    logic [31:0] m_data = 32'h0, m_ctrl = 32'h1, m_raw = 32'h0;
    logic [31:0] v_data = 32'h0, v_ctrl = 32'h1, v_raw = 32'h0;
    int          n = 0;
    logic [7:0]  exp_ss   = 8'hFF;
    logic [2:0]  exp_ssen = 3'b111;
    logic        mon_en   = 1'b0;

    typedef struct packed {
        logic [3:0]  ofs;
        logic [3:0]  ws;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [7:0]  idle;
    } vec_t;

    vec_t vt[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic void expect_display(input int slot, input int idx,
                                           input logic [31:0] d, input logic [31:0] c,
                                           input logic [31:0] r,
                                           output logic [7:0] es, output logic [2:0] en);
        logic [7:0] pat;
        es = 8'hFF;
        en = 3'b111;
        if (c[0]) begin
            if (c[1]) pat = r[8*idx +: 8];
            else      pat = {d[12+idx], seg7(d[4*idx +: 4])};
            es = ~pat;
            en = (slot == 0) ? 3'b111 : ~(3'b001 << idx);
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] ofs);
        case (ofs)
            4'h0:    return m_data;
            4'h4:    return m_ctrl;
            4'h8:    return m_raw;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [3:0] ofs, input logic [3:0] ws, input logic [31:0] wd);
        logic [31:0] mask;
        mask = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
        case (ofs)
            4'h0:    m_data = ((m_data & ~mask) | (wd & mask)) & 32'h0000_7FFF;
            4'h4:    m_ctrl = ((m_ctrl & ~mask) | (wd & mask)) & 32'h0000_0003;
            4'h8:    m_raw  = ((m_raw  & ~mask) | (wd & mask)) & 32'h00FF_FFFF;
            default: ;
        endcase
    endtask

    // Display reference: edge count since reset gives slot and digit directly.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            n = 0;
            v_data = 32'h0; v_ctrl = 32'h1; v_raw = 32'h0;
            exp_ss = 8'hFF; exp_ssen = 3'b111;
        end else begin
            expect_display(n % T, (n / T) % 3, v_data, v_ctrl, v_raw, exp_ss, exp_ssen);
            v_data = m_data; v_ctrl = m_ctrl; v_raw = m_raw;
            n++;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("ss", 32'(ss), 32'(exp_ss));
            chk("ssen", 32'(ssen), 32'(exp_ssen));
        end
    end

    // lat = edges until ready (0 = next edge), -1 when no ready within the bound.
    task automatic bus_op(input logic [31:0] addr, input logic [3:0] ws, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd);
        @(negedge clk);
        bus_i.iomem_valid = 1'b1;
        bus_i.iomem_addr  = addr;
        bus_i.iomem_wstrb = ws;
        bus_i.iomem_wdata = wd;
        lat = -1;
        rd  = 32'h0;
        for (int i = 0; i < 4 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (bus_i.iomem_ready) begin
                lat = i;
                rd  = bus_i.iomem_rdata;
            end
        end
        bus_i.iomem_valid = 1'b0;
        bus_i.iomem_wstrb = 4'h0;
        if (lat >= 0 && addr[31:4] == BASE[31:4] && ws != 4'h0) model_write(addr[3:0], ws, wd);
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] rd, exp_rd, addr;
        logic [3:0]  ofs, ws;
        logic [31:0] wd;
        logic        sel;

        bus_i.iomem_valid = 1'b0;
        bus_i.iomem_wstrb = 4'h0;
        bus_i.iomem_addr  = 32'h0;
        bus_i.iomem_wdata = 32'h0;

        //            ofs   ws     wd             rd            idle
        vt[0]  = '{4'h0, 4'h0, 32'h0,         32'h0,         8'd0};
        vt[1]  = '{4'h4, 4'h0, 32'h0,         32'h1,         8'd0};
        vt[2]  = '{4'h8, 4'h0, 32'h0,         32'h0,         8'd0};
        vt[3]  = '{4'h0, 4'hF, 32'h0000_41A3, 32'h0,         8'd14};
        vt[4]  = '{4'h0, 4'h0, 32'h0,         32'h0000_41A3, 8'd0};
        vt[5]  = '{4'h0, 4'h1, 32'h0000_00EE, 32'h0,         8'd0};
        vt[6]  = '{4'h0, 4'h0, 32'h0,         32'h0000_41EE, 8'd3};
        vt[7]  = '{4'h4, 4'hF, 32'h0000_0003, 32'h0,         8'd0};
        vt[8]  = '{4'h8, 4'hF, 32'h00FF_0081, 32'h0,         8'd14};
        vt[9]  = '{4'h8, 4'h0, 32'h0,         32'h00FF_0081, 8'd0};
        vt[10] = '{4'hC, 4'h0, 32'h0,         32'h0,         8'd0};
        vt[11] = '{4'hC, 4'hF, 32'hFFFF_FFFF, 32'h0,         8'd0};
        vt[12] = '{4'hC, 4'h0, 32'h0,         32'h0,         8'd0};
        vt[13] = '{4'h8, 4'h4, 32'h00AB_0000, 32'h0,         8'd0};
        vt[14] = '{4'h8, 4'h0, 32'h0,         32'h00AB_0081, 8'd5};
        vt[15] = '{4'h4, 4'hF, 32'h0000_0000, 32'h0,         8'd9};
        vt[16] = '{4'h4, 4'h0, 32'h0,         32'h0,         8'd0};
        vt[17] = '{4'h4, 4'hF, 32'hFFFF_FFF1, 32'h0,         8'd9};
        vt[18] = '{4'h4, 4'h0, 32'h0,         32'h1,         8'd0};
        vt[19] = '{4'h0, 4'hF, 32'hFFFF_FFFF, 32'h0,         8'd0};
        vt[20] = '{4'h0, 4'h0, 32'h0,         32'h0000_7FFF, 8'd0};
        vt[21] = '{4'h1, 4'h0, 32'h0,         32'h0,         8'd0};

        // Reset state, then release on a falling edge.
        #7;
        chk("reset_ss", 32'(ss), 32'hFF);
        chk("reset_ssen", 32'(ssen), 32'h7);
        chk("reset_ready", 32'(bus_i.iomem_ready), 32'h0);
        chk("reset_rdata", bus_i.iomem_rdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        mon_en = 1'b1;

        for (int k = 0; k < $size(vt); k++) begin
            bus_op(BASE | 32'(vt[k].ofs), vt[k].ws, vt[k].wd, lat, rd);
            chk($sformatf("vec%0d_latency", k), 32'(lat), 32'h0);
            if (vt[k].ws == 4'h0) chk($sformatf("vec%0d_rdata", k), rd, vt[k].rd);
            repeat (int'(vt[k].idle)) @(posedge clk);
        end

        // Held valid: acked every other cycle, rdata zero between acks.
        @(negedge clk);
        bus_i.iomem_valid = 1'b1;
        bus_i.iomem_addr  = BASE | 32'h4;
        bus_i.iomem_wstrb = 4'h0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("held_ready%0d", i), 32'(bus_i.iomem_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("held_rdata%0d", i), bus_i.iomem_rdata, (i % 2 == 0) ? m_ctrl : 32'h0);
        end
        bus_i.iomem_valid = 1'b0;
        @(posedge clk);

        // Unselected address never acks.
        @(negedge clk);
        bus_i.iomem_valid = 1'b1;
        bus_i.iomem_addr  = 32'h0400_0000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("unsel_ready", 32'(bus_i.iomem_ready), 32'h0);
            chk("unsel_rdata", bus_i.iomem_rdata, 32'h0);
        end
        bus_i.iomem_valid = 1'b0;

        // Randomized traffic against the register/display model.
        for (int k = 0; k < 60; k++) begin
            ofs = 4'(4 * $urandom_range(3));
            if ($urandom_range(7) == 0) ofs = 4'($urandom_range(15));
            ws  = ($urandom_range(1) == 1) ? 4'($urandom_range(15)) : 4'h0;
            wd  = $urandom;
            if (ofs == 4'h4 && $urandom_range(3) != 0) wd[0] = 1'b1;
            addr = BASE | 32'(ofs);
            if ($urandom_range(9) == 0) addr = addr ^ (32'h10 << $urandom_range(27));
            sel    = (addr[31:4] == BASE[31:4]);
            exp_rd = model_read(ofs);
            bus_op(addr, ws, wd, lat, rd);
            chk("rand_latency", 32'(lat), sel ? 32'h0 : 32'hFFFF_FFFF);
            if (sel && ws == 4'h0) chk("rand_rdata", rd, exp_rd);
            repeat ($urandom_range(2 * T)) @(posedge clk);
        end

        // Reset while a read is pending: ack dropped, registers back to reset.
        @(negedge clk);
        bus_i.iomem_valid = 1'b1;
        bus_i.iomem_addr  = BASE;
        bus_i.iomem_wstrb = 4'h0;
        #2;
        resetn = 1'b0;
        m_data = 32'h0; m_ctrl = 32'h1; m_raw = 32'h0;
        #1;
        chk("async_rst_ss", 32'(ss), 32'hFF);
        chk("async_rst_ssen", 32'(ssen), 32'h7);
        @(posedge clk); #1;
        chk("rst_ready", 32'(bus_i.iomem_ready), 32'h0);
        bus_i.iomem_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ofs    = 4'(4 * k);
            exp_rd = model_read(ofs);
            bus_op(BASE | 32'(ofs), 4'h0, 32'h0, lat, rd);
            chk("post_rst_latency", 32'(lat), 32'h0);
            chk("post_rst_rdata", rd, exp_rd);
        end
        repeat (3 * T + 2) @(posedge clk);

        @(negedge clk);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
